// File: rtl/prbs_check_pkg.sv
// Shared types and helpers for the PRBS path checker: FSM state encoding,
// PRBS7 tap definition, LFSR step and saturating increment.
package prbs_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // x^7 + x^6 + 1: feedback taps are the polynomial exponents of the PRBS7 generator.
  localparam int unsigned PRBS_W     = 7;
  localparam int unsigned PRBS_TAP_A = 7;
  localparam int unsigned PRBS_TAP_B = 6;

  // Fibonacci step shifting toward the MSB; the new LSB is the XOR of the two top taps.
  // Widths up to 32 bits are supported; the result is masked to w bits.
  function automatic logic [31:0] prbs_next(input logic [31:0] lfsr, input int unsigned w);
    logic [31:0] mask;
    logic [31:0] taps;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    taps = (lfsr >> (w - 1)) ^ (lfsr >> (w - 1 - (PRBS_TAP_A - PRBS_TAP_B)));
    return ((lfsr << 1) | {31'd0, taps[0]}) & mask;
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (cnt >= max_v) ? max_v : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// PRBS generator register: loads a seed (zero replaced by all-ones so the
// sequence can never lock up) and advances one step per enabled edge.
module prbs_lfsr
  import prbs_check_pkg::*;
#(
  parameter int LFSR_W = PRBS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic              msb_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == '0) ? '1 : seed_i;
    end else if (adv_i) begin
      lfsr_d = LFSR_W'(prbs_next(32'(lfsr_q), LFSR_W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= '1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign msb_o = lfsr_q[LFSR_W-1];

endmodule

// File: rtl/prbs_path_checker.sv
// Drives a PRBS stream into a register-to-register timing cell and compares the
// captured bit against the same stream delayed by LATENCY flop stages.
module prbs_path_checker
  import prbs_check_pkg::*;
#(
  parameter int LFSR_W  = PRBS_W,
  parameter int LATENCY = 2,
  parameter int MAX_LAT = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]  num_bits,
  output logic              pat_out,
  input  logic              chk_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_flag,
  output logic [1:0]        dbg_state
);

  // Fill counter only has to reach LATENCY, which is bounded by MAX_LAT.
  localparam int FILL_W = $clog2(MAX_LAT + 1) + 1;

  state_e             state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [LATENCY:0]   hist_q, hist_d;
  logic               pat_q, pat_d;
  logic [CNT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               flag_q, flag_d;
  logic               lfsr_load;
  logic               lfsr_adv;
  logic               lfsr_msb;

  prbs_lfsr #(
    .LFSR_W (LFSR_W)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (lfsr_load),
    .adv_i  (lfsr_adv),
    .seed_i (seed),
    .msb_o  (lfsr_msb)
  );

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    hist_d    = hist_q;
    pat_d     = 1'b0;
    bit_d     = bit_q;
    err_d     = err_q;
    flag_d    = flag_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          hist_d    = '0;
          bit_d     = '0;
          err_d     = '0;
          flag_d    = 1'b0;
          fill_d    = '0;
          state_d   = FILL;
        end
      end

      FILL: begin
        lfsr_adv = 1'b1;
        hist_d   = {hist_q[LATENCY-1:0], lfsr_msb};
        pat_d    = lfsr_msb;
        if (fill_q == FILL_W'(LATENCY)) begin
          state_d = CHECK;
        end else begin
          fill_d = fill_q + 1'b1;
        end
        if (stop) begin
          state_d = DONE;
        end
      end

      CHECK: begin
        lfsr_adv = 1'b1;
        hist_d   = {hist_q[LATENCY-1:0], lfsr_msb};
        pat_d    = lfsr_msb;
        bit_d    = bit_q + 1'b1;
        // hist_q[LATENCY] is the bit that left pat_out LATENCY edges ago.
        if (chk_in != hist_q[LATENCY]) begin
          err_d  = CNT_W'(sat_inc(32'(err_q), CNT_W));
          flag_d = 1'b1;
        end
        if (stop || ((num_bits != '0) && (bit_d == num_bits))) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Keep the cell input quiet on every cycle that is not part of a run.
    if ((state_d != FILL) && (state_d != CHECK)) begin
      pat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fill_q  <= '0;
      hist_q  <= '0;
      pat_q   <= 1'b0;
      bit_q   <= '0;
      err_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
    end
  end

  assign pat_out   = pat_q;
  assign busy      = (state_q == FILL) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign bit_cnt   = bit_q;
  assign err_cnt   = err_q;
  assign err_flag  = flag_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prbs_path_checker.sv
// Bench for prbs_path_checker: DFF loopback around the DUT, a sequence-level
// PRBS model predicting every output each cycle, plus directed literal checks.
module tb_prbs_path_checker;

  localparam int LAT = 2;
  localparam int CW  = 16;
  localparam int LW  = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (CNT_W = 16) ----------------
  logic          start = 1'b0;
  logic          stop  = 1'b0;
  logic [LW-1:0] seed  = '0;
  logic [CW-1:0] num_bits = '0;
  logic          pat_out, chk_in, busy, done, err_flag;
  logic [CW-1:0] bit_cnt, err_cnt;
  logic [1:0]    dbg_state;

  // Loopback: 2 or 3 flops from pat_out to chk_in, with an optional inversion.
  logic [2:0] dly     = '0;
  logic       dly_sel = 1'b0;
  logic       inv     = 1'b0;
  always @(posedge clk) dly <= {dly[1:0], pat_out};
  assign chk_in = (dly_sel ? dly[2] : dly[1]) ^ inv;

  prbs_path_checker #(.LFSR_W(LW), .LATENCY(LAT), .MAX_LAT(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .seed(seed), .num_bits(num_bits),
    .pat_out(pat_out), .chk_in(chk_in), .busy(busy), .done(done), .bit_cnt(bit_cnt),
    .err_cnt(err_cnt), .err_flag(err_flag), .dbg_state(dbg_state)
  );

  // ---------------- narrow-counter DUT (CNT_W = 4) ----------------
  logic          rst4 = 1'b1;
  logic          start4 = 1'b0;
  logic          stop4  = 1'b0;
  logic [LW-1:0] seed4  = 7'h05;
  logic [3:0]    num_bits4 = '0;
  logic          pat_out4, chk_in4, busy4, done4, err_flag4;
  logic [3:0]    bit_cnt4, err_cnt4;
  logic [1:0]    dbg_state4;
  logic [1:0]    dly4 = '0;
  always @(posedge clk) dly4 <= {dly4[0], pat_out4};
  assign chk_in4 = ~dly4[1];

  prbs_path_checker #(.LFSR_W(LW), .LATENCY(LAT), .MAX_LAT(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .stop(stop4), .seed(seed4), .num_bits(num_bits4),
    .pat_out(pat_out4), .chk_in(chk_in4), .busy(busy4), .done(done4), .bit_cnt(bit_cnt4),
    .err_cnt(err_cnt4), .err_flag(err_flag4), .dbg_state(dbg_state4)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The PRBS7 output sequence obeys b[n] = b[n-7] ^ b[n-6], first 7 bits = seed MSB-first.
  // A run is "edges since start": edges 1..LAT+1 only fill, later edges compare
  // chk_in against b[edge-LAT-2]; pat_out after edge j shows b[j-1].
  bit            prbs_q[$];
  bit            m_active = 1'b0;
  bit            m_done   = 1'b0;
  int            m_edges  = 0;
  logic [CW-1:0] m_bits   = '0;
  logic [CW-1:0] m_err    = '0;
  bit            m_flag   = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    int      e;
    bit      ended;
    logic [LW-1:0] eff;
    if (rst) begin
      m_active = 1'b0; m_done = 1'b0; m_edges = 0;
      m_bits = '0; m_err = '0; m_flag = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        eff = (seed == '0) ? 7'h7F : seed;
        prbs_q.delete();
        for (int i = 0; i < LW; i++) prbs_q.push_back(eff[LW-1-i]);
        m_active = 1'b1; m_edges = 0;
        m_bits = '0; m_err = '0; m_flag = 1'b0;
      end
    end else begin
      e = m_edges + 1;
      while (prbs_q.size() < e) prbs_q.push_back(prbs_q[prbs_q.size()-7] ^ prbs_q[prbs_q.size()-6]);
      ended = stop;
      if (e >= LAT + 2) begin
        m_bits = m_bits + 1'b1;
        if (chk_in !== prbs_q[e-LAT-2]) begin
          if (m_err != '1) m_err = m_err + 1'b1;
          m_flag = 1'b1;
        end
        if ((num_bits != '0) && (m_bits == num_bits)) ended = 1'b1;
      end
      m_edges = e;
      if (ended) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    logic exp_pat;
    exp_pat = (m_active && (m_edges > 0)) ? prbs_q[m_edges-1] : 1'b0;
    check("busy",     32'(busy),     32'(m_active));
    check("done",     32'(done),     32'(m_done));
    check("pat_out",  32'(pat_out),  32'(exp_pat));
    check("bit_cnt",  32'(bit_cnt),  32'(m_bits));
    check("err_cnt",  32'(err_cnt),  32'(m_err));
    check("err_flag", 32'(err_flag), 32'(m_flag));
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [LW-1:0] s, input logic [CW-1:0] nb, input logic sel);
    @(negedge clk);
    seed = s; num_bits = nb; dly_sel = sel; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int busy_n);
    bit seen;
    seen   = 1'b0;
    busy_n = busy ? 1 : 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) busy_n++;
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int   n;
    logic [7:0] pats;
    bit   done4_seen;

    repeat (3) @(negedge clk);
    rst = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    check("reset_bit_cnt",  32'(bit_cnt),  32'd0);
    check("reset_err_cnt",  32'(err_cnt),  32'd0);
    check("reset_busy",     32'(busy),     32'd0);
    check("reset_pat_out",  32'(pat_out),  32'd0);

    // stop in IDLE does nothing
    stop = 1'b1; @(negedge clk); stop = 1'b0; @(negedge clk);
    check("idle_stop_busy", 32'(busy), 32'd0);

    // 1: clean loopback, 100 bits
    start_run(7'h01, 16'd100, 1'b0);
    wait_done(200, n);
    check("t1_busy_cycles", 32'(n),        32'd103);
    check("t1_bit_cnt",     32'(bit_cnt),  32'd100);
    check("t1_err_cnt",     32'(err_cnt),  32'd0);
    check("t1_err_flag",    32'(err_flag), 32'd0);
    @(negedge clk);
    check("t1_done_pulse",  32'(done),     32'd0);

    // 2: one inverted cycle mid-run
    start_run(7'h01, 16'd100, 1'b0);
    repeat (50) @(negedge clk);
    inv = 1'b1; @(negedge clk); inv = 1'b0;
    wait_done(200, n);
    check("t2_bit_cnt",  32'(bit_cnt),  32'd100);
    check("t2_err_cnt",  32'(err_cnt),  32'd1);
    check("t2_err_flag", 32'(err_flag), 32'd1);
    @(negedge clk);

    // 3: one flop too many in the loop
    start_run(7'h01, 16'd127, 1'b1);
    wait_done(300, n);
    check("t3_bit_cnt",     32'(bit_cnt),          32'd127);
    check("t3_err_nonzero", 32'(err_cnt > 16'd40), 32'd1);
    check("t3_err_flag",    32'(err_flag),         32'd1);
    @(negedge clk);

    // 4: zero seed is replaced by all-ones
    start_run(7'h00, 16'd20, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pats[7-i] = pat_out;
    end
    check("t4_first_bits", 32'(pats), 32'hFE);
    wait_done(100, n);
    @(negedge clk);

    // 5: free-run, stop after 500 compares; the stop edge compares once more
    start_run(7'h35, 16'd0, 1'b0);
    repeat (503) @(negedge clk);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    check("t5_done",    32'(done),    32'd1);
    check("t5_bit_cnt", 32'(bit_cnt), 32'd501);
    check("t5_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);

    // 6: 4-bit counters saturate, then asynchronous reset mid-run
    @(negedge clk); start4 = 1'b1; @(negedge clk); start4 = 1'b0;
    repeat (40) @(negedge clk);
    check("t6_err_sat",  32'(err_cnt4),  32'd15);
    check("t6_err_flag", 32'(err_flag4), 32'd1);
    check("t6_busy",     32'(busy4),     32'd1);
    #2 rst4 = 1'b1;
    #1;
    check("t6_rst_pat",  32'(pat_out4),  32'd0);
    check("t6_rst_busy", 32'(busy4),     32'd0);
    check("t6_rst_bits", 32'(bit_cnt4),  32'd0);
    check("t6_rst_err",  32'(err_cnt4),  32'd0);
    check("t6_rst_flag", 32'(err_flag4), 32'd0);
    done4_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst4 = 1'b0;
      done4_seen |= done4;
    end
    check("t6_no_done", 32'(done4_seen), 32'd0);

    // randomized runs against the model
    for (int r = 0; r < 14; r++) begin
      int  nb, stop_at;
      bit  seen;
      nb      = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 200));
      stop_at = (nb == 0) ? int'($urandom_range(1, 250))
                          : (($urandom_range(0, 4) == 0) ? int'($urandom_range(1, nb + 3)) : 1000);
      @(negedge clk);
      seed     = 7'($urandom);
      num_bits = 16'(nb);
      dly_sel  = 1'($urandom_range(0, 1));
      start    = 1'b1;
      stop     = 1'($urandom_range(0, 1));
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      seen = 1'b0;
      for (int cyc = 1; cyc < 400 && !seen; cyc++) begin
        inv   = ($urandom_range(0, 30) == 0);
        start = ($urandom_range(0, 20) == 0);
        stop  = (cyc == stop_at);
        if (r == 6 && cyc == 40) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          break;
        end
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      start = 1'b0; stop = 1'b0; inv = 1'b0;
      if (r != 6) check("rand_run_done", 32'(seen), 32'd1);
      repeat (2) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
